chimera_pmu_sequencer: RTL and testbench

Per-cluster power sequencer that drives the cluster reset, clock-gate and isolation controls of `chimera_top_wrapper` (`pmu_rst_clusters_ni`, `pmu_clkgate_en_clusters_i`, `pmu_iso_en_clusters_i`) and consumes `pmu_iso_ack_clusters_o`. It sits directly upstream of the SoC top and replaces the static tie-offs used in simulation. Software or the bench requests power-up or power-down per cluster. The block then runs a fixed ordered sequence with counted reset hold and ack-with-timeout isolation handshakes.

---
 rtl/chimera_pkg.sv | 36 +++
 rtl/chimera_pmu_cluster_fsm.sv | 119 +++++++++++
 rtl/chimera_pmu_sequencer.sv | 52 +++++
 tb/tb_chimera_pmu_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chimera_pkg.sv
// Shared types for the Chimera power-management sequencer: per-cluster FSM
// states and the (reset, clock-enable, isolation) drive triple each state implies.
package chimera_pkg;

  typedef enum logic [2:0] {
    PMU_OFF    = 3'd0,
    PMU_UP_RST = 3'd1,
    PMU_UP_ISO = 3'd2,
    PMU_ON     = 3'd3,
    PMU_DN_ISO = 3'd4,
    PMU_DN_RST = 3'd5
  } pmu_state_e;

  typedef struct packed {
    logic rst_n;
    logic clk_en;
    logic iso;
  } pmu_drive_t;

  // Maps a state to the cluster controls; anything unknown falls back to the
  // safe powered-off drive (reset low, clock gated, isolated).
  function automatic pmu_drive_t pmu_drive(input pmu_state_e st);
    pmu_drive_t d;
    d = '{rst_n: 1'b0, clk_en: 1'b0, iso: 1'b1};
    case (st)
      PMU_UP_RST: d = '{rst_n: 1'b0, clk_en: 1'b1, iso: 1'b1};
      PMU_UP_ISO: d = '{rst_n: 1'b1, clk_en: 1'b1, iso: 1'b0};
      PMU_ON:     d = '{rst_n: 1'b1, clk_en: 1'b1, iso: 1'b0};
      PMU_DN_ISO: d = '{rst_n: 1'b1, clk_en: 1'b1, iso: 1'b1};
      PMU_DN_RST: d = '{rst_n: 1'b0, clk_en: 1'b1, iso: 1'b1};
      default:    d = '{rst_n: 1'b0, clk_en: 1'b0, iso: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/chimera_pmu_cluster_fsm.sv
// Power sequencer for a single cluster: one state machine, one shared
// hold/timeout counter and one sticky isolation-timeout flag.
module chimera_pmu_cluster_fsm
  import chimera_pkg::*;
#(
  parameter int unsigned RstHoldCycles    = 8,
  parameter int unsigned AckTimeoutCycles = 256,
  parameter bit          AutoBoot         = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_valid_i,
  input  logic req_on_i,
  output logic req_ready_o,
  input  logic iso_ack_i,
  input  logic timeout_clr_i,
  output logic rst_no,
  output logic clk_en_o,
  output logic iso_en_o,
  output logic on_o,
  output logic busy_o,
  output logic timeout_o
);

  localparam int unsigned CntMax = (RstHoldCycles > AckTimeoutCycles) ? RstHoldCycles
                                                                       : AckTimeoutCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] RstLast  = CntW'(RstHoldCycles - 1);
  localparam logic [CntW-1:0] AckLimit = CntW'(AckTimeoutCycles);
  localparam logic [CntW-1:0] CntSat   = CntW'(CntMax);

  pmu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            boot_q;
  logic            timeout_q;
  logic            set_timeout;
  logic            accept;
  pmu_drive_t      drive;

  assign req_ready_o = (state_q == PMU_OFF) || (state_q == PMU_ON);
  assign accept      = req_valid_i && req_ready_o;

  // Next-state decode; the ack check wins over the timeout in the same cycle,
  // and redundant requests are accepted without leaving OFF or ON.
  always_comb begin
    state_d     = state_q;
    set_timeout = 1'b0;
    unique case (state_q)
      PMU_OFF: begin
        if (boot_q || (accept && req_on_i)) state_d = PMU_UP_RST;
      end
      PMU_UP_RST: begin
        if (cnt_q == RstLast) state_d = PMU_UP_ISO;
      end
      PMU_UP_ISO: begin
        if (!iso_ack_i) begin
          state_d = PMU_ON;
        end else if (cnt_q == AckLimit) begin
          state_d     = PMU_ON;
          set_timeout = 1'b1;
        end
      end
      PMU_ON: begin
        if (accept && !req_on_i) state_d = PMU_DN_ISO;
      end
      PMU_DN_ISO: begin
        if (iso_ack_i) begin
          state_d = PMU_DN_RST;
        end else if (cnt_q == AckLimit) begin
          state_d     = PMU_DN_RST;
          set_timeout = 1'b1;
        end
      end
      PMU_DN_RST: begin
        if (cnt_q == RstLast) state_d = PMU_OFF;
      end
      default: state_d = PMU_OFF;
    endcase
  end

  // Counter restarts at zero on every state entry and otherwise saturates.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntSat) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // State, counter, one-shot boot request and sticky timeout (set beats clear).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= PMU_OFF;
      cnt_q     <= '0;
      boot_q    <= AutoBoot;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      boot_q  <= 1'b0;
      if (set_timeout) begin
        timeout_q <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign drive     = pmu_drive(state_q);
  assign rst_no    = drive.rst_n;
  assign clk_en_o  = drive.clk_en;
  assign iso_en_o  = drive.iso;
  assign on_o      = (state_q == PMU_ON);
  assign busy_o    = !req_ready_o;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/chimera_pmu_sequencer.sv
// Per-cluster power sequencer feeding the reset, clock-gate and isolation
// controls of the Chimera SoC top; one independent FSM per cluster.
module chimera_pmu_sequencer
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters      = 5,
  parameter int unsigned RstHoldCycles    = 8,
  parameter int unsigned AckTimeoutCycles = 256,
  parameter bit          AutoBoot         = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumClusters-1:0] req_valid_i,
  input  logic [NumClusters-1:0] req_on_i,
  output logic [NumClusters-1:0] req_ready_o,
  output logic [NumClusters-1:0] pmu_rst_clusters_no,
  output logic [NumClusters-1:0] pmu_clkgate_en_clusters_o,
  output logic [NumClusters-1:0] pmu_iso_en_clusters_o,
  input  logic [NumClusters-1:0] pmu_iso_ack_clusters_i,
  output logic [NumClusters-1:0] cluster_on_o,
  output logic [NumClusters-1:0] timeout_o,
  input  logic [NumClusters-1:0] timeout_clr_i,
  output logic                   busy_o
);

  logic [NumClusters-1:0] busy_vec;

  for (genvar i = 0; i < NumClusters; i++) begin : g_cluster
    chimera_pmu_cluster_fsm #(
      .RstHoldCycles   (RstHoldCycles),
      .AckTimeoutCycles(AckTimeoutCycles),
      .AutoBoot        (AutoBoot)
    ) u_fsm (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i[i]),
      .req_on_i     (req_on_i[i]),
      .req_ready_o  (req_ready_o[i]),
      .iso_ack_i    (pmu_iso_ack_clusters_i[i]),
      .timeout_clr_i(timeout_clr_i[i]),
      .rst_no       (pmu_rst_clusters_no[i]),
      .clk_en_o     (pmu_clkgate_en_clusters_o[i]),
      .iso_en_o     (pmu_iso_en_clusters_o[i]),
      .on_o         (cluster_on_o[i]),
      .busy_o       (busy_vec[i]),
      .timeout_o    (timeout_o[i])
    );
  end

  assign busy_o = |busy_vec;

endmodule

// File: tb/tb_chimera_pmu_sequencer.sv
// Scoreboard bench for chimera_pmu_sequencer: stimulus pushes the expected
// output snapshot and edge index of every output change; a monitor pops one
// entry per observed change.
module tb_chimera_pmu_sequencer;

  localparam int NC = 5;

  localparam int S_OFF    = 0;
  localparam int S_UP_RST = 1;
  localparam int S_UP_ISO = 2;
  localparam int S_ON     = 3;
  localparam int S_DN_ISO = 4;
  localparam int S_DN_RST = 5;

  typedef struct packed {
    logic [NC-1:0] rst_n;
    logic [NC-1:0] clk_en;
    logic [NC-1:0] iso;
    logic [NC-1:0] on;
    logic [NC-1:0] to;
    logic [NC-1:0] ready;
    logic          busy;
  } snap_t;

  typedef struct {
    int    at;
    int    via;
    snap_t snap;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NC-1:0] req_valid;
  logic [NC-1:0] req_on;
  logic [NC-1:0] req_ready;
  logic [NC-1:0] rst_no;
  logic [NC-1:0] clk_en;
  logic [NC-1:0] iso_en;
  logic [NC-1:0] iso_ack;
  logic [NC-1:0] cl_on;
  logic [NC-1:0] to;
  logic [NC-1:0] to_clr;
  logic          busy;

  int            cyc;
  int            n_cmp = 0;
  int            n_bad = 0;
  exp_t          sb_q[$];
  int            m_st[NC];
  logic [NC-1:0] m_to;
  logic [2:0]    hist[NC];
  int            ack_dly[NC];
  logic [NC-1:0] stuck_lo;

  chimera_pmu_sequencer #(
    .NumClusters     (NC),
    .RstHoldCycles   (8),
    .AckTimeoutCycles(16),
    .AutoBoot        (1'b1)
  ) dut (
    .clk_i                    (clk_i),
    .rst_ni                   (rst_ni),
    .req_valid_i              (req_valid),
    .req_on_i                 (req_on),
    .req_ready_o              (req_ready),
    .pmu_rst_clusters_no      (rst_no),
    .pmu_clkgate_en_clusters_o(clk_en),
    .pmu_iso_en_clusters_o    (iso_en),
    .pmu_iso_ack_clusters_i   (iso_ack),
    .cluster_on_o             (cl_on),
    .timeout_o                (to),
    .timeout_clr_i            (to_clr),
    .busy_o                   (busy)
  );

  // Free-running 100 MHz clock.
  always #5 clk_i = ~clk_i;

  // Edge index since the last reset release; stamps every observed change.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  // Isolation ack model: iso_en delayed by a per-cluster number of cycles.
  always @(posedge clk_i or negedge rst_ni) begin
    for (int i = 0; i < NC; i++) begin
      if (!rst_ni) hist[i] <= 3'b111;
      else         hist[i] <= {hist[i][1:0], iso_en[i]};
    end
  end

  // Ack selection, with an override that pins the ack low.
  always_comb begin
    iso_ack = '0;
    for (int i = 0; i < NC; i++) begin
      if (stuck_lo[i])        iso_ack[i] = 1'b0;
      else if (ack_dly[i] == 0) iso_ack[i] = iso_en[i];
      else                    iso_ack[i] = hist[i][ack_dly[i]-1];
    end
  end

  function automatic snap_t model_snap();
    snap_t s;
    s = '0;
    for (int i = 0; i < NC; i++) begin
      case (m_st[i])
        S_UP_RST: begin s.rst_n[i] = 1'b0; s.clk_en[i] = 1'b1; s.iso[i] = 1'b1; end
        S_UP_ISO: begin s.rst_n[i] = 1'b1; s.clk_en[i] = 1'b1; s.iso[i] = 1'b0; end
        S_ON:     begin s.rst_n[i] = 1'b1; s.clk_en[i] = 1'b1; s.iso[i] = 1'b0; end
        S_DN_ISO: begin s.rst_n[i] = 1'b1; s.clk_en[i] = 1'b1; s.iso[i] = 1'b1; end
        S_DN_RST: begin s.rst_n[i] = 1'b0; s.clk_en[i] = 1'b1; s.iso[i] = 1'b1; end
        default:  begin s.rst_n[i] = 1'b0; s.clk_en[i] = 1'b0; s.iso[i] = 1'b1; end
      endcase
      s.on[i]    = (m_st[i] == S_ON);
      s.ready[i] = (m_st[i] == S_OFF) || (m_st[i] == S_ON);
    end
    s.to   = m_to;
    s.busy = |(~s.ready);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.rst_n  = rst_no;
    s.clk_en = clk_en;
    s.iso    = iso_en;
    s.on     = cl_on;
    s.to     = to;
    s.ready  = req_ready;
    s.busy   = busy;
    return s;
  endfunction

  // via: 0 = change must follow a clock edge, 1 = must follow reset assertion, 2 = either
  task automatic push_exp(input int at, input int via);
    exp_t e;
    e.at   = at;
    e.via  = via;
    e.snap = model_snap();
    sb_q.push_back(e);
  endtask

  task automatic set_all(input int st);
    for (int i = 0; i < NC; i++) m_st[i] = st;
  endtask

  task automatic wait_until(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 2000) begin
      @(negedge clk_i);
      guard++;
    end
  endtask

  // Raises one request at a negedge; it is sampled at edge t.
  task automatic apply_stimulus(input int cl, input logic on, output int t);
    req_valid[cl] = 1'b1;
    req_on[cl]    = on;
    t             = cyc + 1;
  endtask

  task automatic check_output(input snap_t cur, input int via_now);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("[TB] FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, cur);
    end else begin
      e = sb_q.pop_front();
      if (e.at != cyc || cur !== e.snap || (e.via != 2 && e.via != via_now)) begin
        n_bad++;
        $display("[TB] FAIL event: got cyc=%0d snap=%h via=%0d, required cyc=%0d snap=%h via=%0d",
                 cyc, cur, via_now, e.at, e.snap, e.via);
      end
    end
  endtask

  // Monitor: one scoreboard pop per observed output change.
  initial begin
    snap_t last, cur;
    int    via_now;
    last = 'x;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      via_now = clk_i ? 0 : 1;
      #1;
      cur = dut_snap();
      if (cur !== last) begin
        last = cur;
        check_output(cur, via_now);
      end
    end
  end

  // Directed sequence.
  initial begin
    int t, c;
    rst_ni    = 1'b0;
    req_valid = '0;
    req_on    = '0;
    to_clr    = '0;
    stuck_lo  = '0;
    m_to      = '0;
    for (int i = 0; i < NC; i++) ack_dly[i] = 2;
    set_all(S_OFF);
    push_exp(0, 2);

    // AutoBoot from reset, ack lagging iso by 2 cycles.
    set_all(S_UP_RST); push_exp(1, 0);
    set_all(S_UP_ISO); push_exp(9, 0);
    set_all(S_ON);     push_exp(12, 0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    $display("[TB] reset released, autoboot running");
    wait_until(14);

    // Power-down cluster 2 with a 3-cycle ack.
    ack_dly[2] = 3;
    apply_stimulus(2, 1'b0, t);
    m_st[2] = S_DN_ISO; push_exp(t, 0);
    m_st[2] = S_DN_RST; push_exp(t + 4, 0);
    m_st[2] = S_OFF;    push_exp(t + 12, 0);
    @(negedge clk_i); req_valid = '0;
    wait_until(t + 14);

    // Power cluster 2 back up.
    apply_stimulus(2, 1'b1, t);
    m_st[2] = S_UP_RST; push_exp(t, 0);
    m_st[2] = S_UP_ISO; push_exp(t + 8, 0);
    m_st[2] = S_ON;     push_exp(t + 12, 0);
    @(negedge clk_i); req_valid = '0;
    wait_until(t + 14);

    // Ack stuck low in DN_ISO: timeout, with a clear landing on the set cycle.
    stuck_lo[2] = 1'b1;
    apply_stimulus(2, 1'b0, t);
    m_st[2] = S_DN_ISO; push_exp(t, 0);
    @(negedge clk_i); req_valid = '0;
    wait_until(t + 16);
    to_clr[2] = 1'b1;
    m_st[2] = S_DN_RST; m_to[2] = 1'b1; push_exp(t + 17, 0);
    @(negedge clk_i); to_clr[2] = 1'b0;
    m_st[2] = S_OFF; push_exp(t + 25, 0);
    wait_until(t + 27);
    stuck_lo[2] = 1'b0;

    // Clear the sticky timeout.
    to_clr[2] = 1'b1;
    m_to[2]   = 1'b0; push_exp(cyc + 1, 0);
    @(negedge clk_i); to_clr[2] = 1'b0;
    c = cyc; wait_until(c + 3);

    // Redundant requests: power-up while ON, power-down while OFF.
    req_valid[0] = 1'b1; req_on[0] = 1'b1;
    req_valid[2] = 1'b1; req_on[2] = 1'b0;
    @(negedge clk_i); req_valid = '0;
    c = cyc; wait_until(c + 4);

    // Power-down request held through a power-up sequence.
    apply_stimulus(2, 1'b1, t);
    m_st[2] = S_UP_RST; push_exp(t, 0);
    m_st[2] = S_UP_ISO; push_exp(t + 8, 0);
    m_st[2] = S_ON;     push_exp(t + 12, 0);
    m_st[2] = S_DN_ISO; push_exp(t + 13, 0);
    m_st[2] = S_DN_RST; push_exp(t + 17, 0);
    m_st[2] = S_OFF;    push_exp(t + 25, 0);
    @(negedge clk_i); req_on[2] = 1'b0;
    wait_until(t + 13);
    req_valid = '0;
    wait_until(t + 27);

    // Reset asserted while cluster 2 sits in UP_ISO, then a fresh autoboot.
    apply_stimulus(2, 1'b1, t);
    m_st[2] = S_UP_RST; push_exp(t, 0);
    m_st[2] = S_UP_ISO; push_exp(t + 8, 0);
    @(negedge clk_i); req_valid = '0;
    wait_until(t + 9);
    set_all(S_OFF); push_exp(0, 1);
    rst_ni = 1'b0;
    set_all(S_UP_RST); push_exp(1, 0);
    set_all(S_UP_ISO); push_exp(9, 0);
    m_st[0] = S_ON; m_st[1] = S_ON; m_st[3] = S_ON; m_st[4] = S_ON; push_exp(12, 0);
    m_st[2] = S_ON; push_exp(13, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    wait_until(16);

    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL missing_event: got no change, required cyc=%0d snap=%h", e.at, e.snap);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
